// File: rtl/clock_pkg.sv
// Shared widths, limits and the time-of-day bundle
// used by the second-tick timekeeper and its helpers.
package clock_pkg;

  localparam int SEC_W  = 6;
  localparam int MIN_W  = 6;
  localparam int HOUR_W = 5;

  localparam int SEC_MAX = 59;
  localparam int MIN_MAX = 59;

  localparam int unsigned CMOS_HZ = 100000000;

  typedef struct packed {
    logic [HOUR_W-1:0] hours;
    logic [MIN_W-1:0]  minutes;
    logic [SEC_W-1:0]  seconds;
  } time_t;

  function automatic logic time_valid(
    input time_t t,
    input int    hmax
  );
    return (int'(t.hours) < hmax) &&
           (int'(t.minutes) <= MIN_MAX) &&
           (int'(t.seconds) <= SEC_MAX);
  endfunction

endpackage

// File: rtl/edge_synchronizer.sv
// Multi-flop synchronizer with a history flop that
// emits a registered one-cycle pulse per rising edge.
module edge_synchronizer #(
  parameter int STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic async_i,
  output logic rise_o
);

  logic [STAGES-1:0] sync_q;
  logic              hist_q;
  logic              rise_q;
  logic              sync_w;

  assign sync_w = sync_q[STAGES-1];

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sync_q <= '0;
      hist_q <= 1'b0;
      rise_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], async_i};
      hist_q <= sync_w;
      rise_q <= sync_w & ~hist_q;
    end
  end

  assign rise_o = rise_q;

endmodule

// File: rtl/second_tick_timekeeper.sv
// Time-of-day counter advanced by the one-second wave,
// with time-set load and lost-tick watchdog.
module second_tick_timekeeper
  import clock_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int HOURS_MAX      = 12,
  parameter int TIMEOUT_CYCLES = 150000000
) (
  input  logic              cmosClock,
  input  logic              resetN,
  input  logic              secondClock,
  input  logic              setValid,
  input  logic [HOUR_W-1:0] setHours,
  input  logic [MIN_W-1:0]  setMinutes,
  input  logic [SEC_W-1:0]  setSeconds,
  output logic              setReady,
  output logic              setError,
  output logic [SEC_W-1:0]  seconds,
  output logic [MIN_W-1:0]  minutes,
  output logic [HOUR_W-1:0] hours,
  output logic              secondTick,
  output logic              minuteTick,
  output logic              hourTick,
  output logic              tickLost
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_TOP = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [HOUR_W-1:0] HR_TOP = HOUR_W'(HOURS_MAX - 1);
  localparam logic [MIN_W-1:0]  MN_TOP = MIN_W'(MIN_MAX);
  localparam logic [SEC_W-1:0]  SC_TOP = SEC_W'(SEC_MAX);

  if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
    $error("SYNC_STAGES out of range");
  end
  if (HOURS_MAX != 12 && HOURS_MAX != 24) begin : g_bad_hours
    $error("HOURS_MAX must be 12 or 24");
  end

  time_t            cur_q, cur_d;
  time_t            set_w;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ready_q;
  logic             sec_tick_q, sec_tick_d;
  logic             min_tick_q, min_tick_d;
  logic             hr_tick_q, hr_tick_d;
  logic             set_err_q, set_err_d;
  logic             rise_w;
  logic             set_req;
  logic             set_ok;
  logic             set_bad;
  logic             adv;

  edge_synchronizer #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk_i   (cmosClock),
    .rst_n_i (resetN),
    .async_i (secondClock),
    .rise_o  (rise_w)
  );

  assign set_w.hours   = setHours;
  assign set_w.minutes = setMinutes;
  assign set_w.seconds = setSeconds;

  assign set_req = ready_q & setValid;
  assign set_ok  = set_req & time_valid(set_w, HOURS_MAX);
  assign set_bad = set_req & ~set_ok;
  // An accepted load swallows a coincident edge entirely.
  assign adv     = rise_w & ~set_ok;

  always_comb begin
    cur_d      = cur_q;
    sec_tick_d = 1'b0;
    min_tick_d = 1'b0;
    hr_tick_d  = 1'b0;
    set_err_d  = set_bad;
    cnt_d      = (cnt_q == CNT_TOP) ? cnt_q : cnt_q + 1'b1;
    unique case (1'b1)
      set_ok: begin
        cur_d = set_w;
        cnt_d = '0;
      end
      adv: begin
        cnt_d      = '0;
        sec_tick_d = 1'b1;
        if (cur_q.seconds == SC_TOP) begin
          cur_d.seconds = '0;
          min_tick_d    = 1'b1;
          if (cur_q.minutes == MN_TOP) begin
            cur_d.minutes = '0;
            hr_tick_d     = 1'b1;
            cur_d.hours   = (cur_q.hours == HR_TOP) ?
                            '0 : cur_q.hours + 1'b1;
          end else begin
            cur_d.minutes = cur_q.minutes + 1'b1;
          end
        end else begin
          cur_d.seconds = cur_q.seconds + 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge cmosClock or negedge resetN) begin
    if (!resetN) begin
      cur_q      <= '0;
      cnt_q      <= '0;
      ready_q    <= 1'b0;
      sec_tick_q <= 1'b0;
      min_tick_q <= 1'b0;
      hr_tick_q  <= 1'b0;
      set_err_q  <= 1'b0;
    end else begin
      cur_q      <= cur_d;
      cnt_q      <= cnt_d;
      ready_q    <= 1'b1;
      sec_tick_q <= sec_tick_d;
      min_tick_q <= min_tick_d;
      hr_tick_q  <= hr_tick_d;
      set_err_q  <= set_err_d;
    end
  end

  assign setReady   = ready_q;
  assign setError   = set_err_q;
  assign seconds    = cur_q.seconds;
  assign minutes    = cur_q.minutes;
  assign hours      = cur_q.hours;
  assign secondTick = sec_tick_q;
  assign minuteTick = min_tick_q;
  assign hourTick   = hr_tick_q;
  assign tickLost   = (cnt_q == CNT_TOP);

endmodule

// File: tb/tb_second_tick_timekeeper.sv
// Scoreboard bench: expected output vectors are queued
// with their due cycle and compared when that cycle comes.
module tb_second_tick_timekeeper;

  localparam int TMO = 50;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       sclk;
  logic       set_v;
  logic [4:0] set_h;
  logic [5:0] set_m;
  logic [5:0] set_s;

  logic       rdy, serr, stk, mtk, htk, lost;
  logic [5:0] sec, mn;
  logic [4:0] hr;

  logic       rdy24, serr24, stk24, mtk24, htk24, lost24;
  logic [5:0] sec24, mn24;
  logic [4:0] hr24;

  second_tick_timekeeper #(
    .SYNC_STAGES    (2),
    .HOURS_MAX      (12),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .cmosClock   (clk),
    .resetN      (rst_n),
    .secondClock (sclk),
    .setValid    (set_v),
    .setHours    (set_h),
    .setMinutes  (set_m),
    .setSeconds  (set_s),
    .setReady    (rdy),
    .setError    (serr),
    .seconds     (sec),
    .minutes     (mn),
    .hours       (hr),
    .secondTick  (stk),
    .minuteTick  (mtk),
    .hourTick    (htk),
    .tickLost    (lost)
  );

  second_tick_timekeeper #(
    .SYNC_STAGES    (2),
    .HOURS_MAX      (24),
    .TIMEOUT_CYCLES (TMO)
  ) dut24 (
    .cmosClock   (clk),
    .resetN      (rst_n),
    .secondClock (sclk),
    .setValid    (set_v),
    .setHours    (set_h),
    .setMinutes  (set_m),
    .setSeconds  (set_s),
    .setReady    (rdy24),
    .setError    (serr24),
    .seconds     (sec24),
    .minutes     (mn24),
    .hours       (hr24),
    .secondTick  (stk24),
    .minuteTick  (mtk24),
    .hourTick    (htk24),
    .tickLost    (lost24)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  typedef struct {
    int          cyc;
    logic [31:0] vec;
    string       tag;
  } exp_t;

  exp_t sb[$];

  logic [4:0] mh;
  logic [5:0] mm;
  logic [5:0] ms;
  int         last_clear;

  function automatic logic tl_at(input int x);
    return (x - last_clear) >= TMO;
  endfunction

  function automatic logic [31:0] obs12();
    return {9'b0, hr, mn, sec, stk, mtk, htk, serr, lost, rdy};
  endfunction

  task automatic push(
    input int    c,
    input logic  st,
    input logic  mt,
    input logic  ht,
    input logic  se,
    input string tag
  );
    exp_t e;
    e.cyc = c;
    e.vec = {9'b0, mh, mm, ms, st, mt, ht, se, tl_at(c), 1'b1};
    e.tag = tag;
    sb.push_back(e);
  endtask

  task automatic m_advance(
    output logic st,
    output logic mt,
    output logic ht
  );
    st = 1'b1;
    mt = 1'b0;
    ht = 1'b0;
    if (ms == 6'd59) begin
      ms = 6'd0;
      mt = 1'b1;
      if (mm == 6'd59) begin
        mm = 6'd0;
        ht = 1'b1;
        mh = 5'((int'(mh) + 1) % 12);
      end else begin
        mm = mm + 6'd1;
      end
    end else begin
      ms = ms + 6'd1;
    end
  endtask

  always @(negedge clk) begin : mon
    exp_t e;
    if (sb.size() != 0 && sb[0].cyc < cyc) begin
      check("stale", 32'(cyc), 32'(sb[0].cyc));
      e = sb.pop_front();
    end
    if (sb.size() != 0 && sb[0].cyc == cyc) begin
      e = sb.pop_front();
      check(e.tag, obs12(), e.vec);
    end else begin
      check("idle_ticks", {29'b0, stk, mtk, htk}, 32'd0);
    end
  end

  task automatic do_rise();
    int   c;
    logic st, mt, ht;
    @(negedge clk);
    sclk = 1'b1;
    c = cyc;
    push(c + 3, 1'b0, 1'b0, 1'b0, 1'b0, "rise_pre");
    m_advance(st, mt, ht);
    last_clear = c + 4;
    push(c + 4, st, mt, ht, 1'b0, "rise");
    push(c + 5, 1'b0, 1'b0, 1'b0, 1'b0, "rise_after");
    repeat (10) @(negedge clk);
    sclk = 1'b0;
    c = cyc;
    push(c + 4, 1'b0, 1'b0, 1'b0, 1'b0, "fall");
    push(c + 5, 1'b0, 1'b0, 1'b0, 1'b0, "fall_after");
    repeat (9) @(negedge clk);
  endtask

  task automatic do_set(
    input logic [4:0] h,
    input logic [5:0] m,
    input logic [5:0] s
  );
    int c;
    @(negedge clk);
    set_v = 1'b1;
    set_h = h;
    set_m = m;
    set_s = s;
    c = cyc;
    if (h < 5'd12 && m < 6'd60 && s < 6'd60) begin
      mh = h;
      mm = m;
      ms = s;
      last_clear = c + 1;
      push(c + 1, 1'b0, 1'b0, 1'b0, 1'b0, "set");
    end else begin
      push(c + 1, 1'b0, 1'b0, 1'b0, 1'b1, "set_err");
      push(c + 2, 1'b0, 1'b0, 1'b0, 1'b0, "set_err_after");
    end
    @(negedge clk);
    set_v = 1'b0;
  endtask

  // Set request timed to land on the same edge as a detected rise.
  task automatic coincident(
    input logic [4:0] h,
    input logic [5:0] m,
    input logic [5:0] s
  );
    int   c;
    logic st, mt, ht;
    @(negedge clk);
    sclk = 1'b1;
    c = cyc;
    repeat (3) @(negedge clk);
    set_v = 1'b1;
    set_h = h;
    set_m = m;
    set_s = s;
    if (h < 5'd12 && m < 6'd60 && s < 6'd60) begin
      mh = h;
      mm = m;
      ms = s;
      last_clear = c + 4;
      push(c + 4, 1'b0, 1'b0, 1'b0, 1'b0, "coin_set");
      push(c + 5, 1'b0, 1'b0, 1'b0, 1'b0, "coin_set_after");
    end else begin
      m_advance(st, mt, ht);
      last_clear = c + 4;
      push(c + 4, st, mt, ht, 1'b1, "coin_bad");
      push(c + 5, 1'b0, 1'b0, 1'b0, 1'b0, "coin_bad_after");
    end
    @(negedge clk);
    set_v = 1'b0;
    repeat (6) @(negedge clk);
    sclk = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin : stim
    int c;
    rst_n = 1'b0;
    sclk  = 1'b0;
    set_v = 1'b0;
    set_h = '0;
    set_m = '0;
    set_s = '0;
    mh = '0;
    mm = '0;
    ms = '0;
    last_clear = 0;

    repeat (3) @(negedge clk);
    check("reset_state", obs12(), 32'd0);
    rst_n = 1'b1;
    c = cyc;
    last_clear = c;
    for (int i = 1; i <= 10; i++)
      push(c + i, 1'b0, 1'b0, 1'b0, 1'b0, "post_reset");
    repeat (10) @(negedge clk);

    repeat (3) do_rise();

    do_set(5'd11, 6'd59, 6'd58);
    repeat (2) do_rise();

    do_set(5'd1, 6'd60, 6'd2);
    coincident(5'd5, 6'd30, 6'd15);
    coincident(5'd7, 6'd61, 6'd0);

    while (cyc < last_clear + TMO - 2) @(negedge clk);
    push(last_clear + TMO - 1, 1'b0, 1'b0, 1'b0, 1'b0, "lost_pre");
    push(last_clear + TMO, 1'b0, 1'b0, 1'b0, 1'b0, "lost_set");
    while (cyc < last_clear + TMO + 5) @(negedge clk);
    do_rise();

    @(negedge clk);
    set_v = 1'b1;
    set_h = 5'd23;
    set_m = 6'd59;
    set_s = 6'd59;
    c = cyc;
    push(c + 1, 1'b0, 1'b0, 1'b0, 1'b1, "set24_rej12");
    push(c + 2, 1'b0, 1'b0, 1'b0, 1'b0, "set24_after");
    @(negedge clk);
    set_v = 1'b0;
    check("set24_time", {15'b0, hr24, mn24, sec24},
          {15'b0, 5'd23, 6'd59, 6'd59});
    @(negedge clk);
    sclk = 1'b1;
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("async_rst24", {15'b0, hr24, mn24, sec24}, 32'd0);
    check("async_rst12", obs12(), 32'd0);
    sclk = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    c = cyc;
    mh = '0;
    mm = '0;
    ms = '0;
    last_clear = c;
    for (int i = 1; i <= 10; i++)
      push(c + i, 1'b0, 1'b0, 1'b0, 1'b0, "rst_drop");
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("rst24_hold", {12'b0, hr24, mn24, sec24, stk24, mtk24, htk24},
            32'd0);
    end

    for (int i = 0; i < 100 && sb.size() != 0; i++) @(negedge clk);
    check("drain", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/second_tick_timekeeper.md
Name: second_tick_timekeeper

Overview:
- Receiving end of the slow square-wave clock that the clock buffer generates. That wave toggles every 50,000,000 cmosClock cycles, so one rising edge arrives per second.
- Synchronises that wave into the cmosClock domain and detects its rising edges. Each edge advances a seconds/minutes/hours time-of-day.
- Drives the hand-position logic: current time plus one-cycle roll-over strobes.
- Also accepts a time-set load and flags a lost second tick.

Parameters:
- SYNC_STAGES, 2, number of synchronizer flops on secondClock (legal range 2..4).
- HOURS_MAX, 12, hour modulus; legal values are 12 (analog face) or 24.
- TIMEOUT_CYCLES, 150000000, cmosClock cycles with no rising edge before tickLost asserts (1.5 s at 100 MHz).

Ports:
- cmosClock  input  1  system clock (100 MHz).
- resetN  input  1  asynchronous, active-low reset.
- secondClock  input  1  slow toggling clock from the clock buffer; asynchronous to cmosClock; one rising edge = one second.
- setValid  input  1  request to load time from the setHours/setMinutes/setSeconds inputs.
- setHours  input  5  value to load, 0..HOURS_MAX-1.
- setMinutes  input  6  value to load, 0..59.
- setSeconds  input  6  value to load, 0..59.
- setReady  output  1  set request can be accepted this cycle.
- setError  output  1  one-cycle pulse: set rejected because a field was out of range.
- seconds  output  6  current seconds, 0..59.
- minutes  output  6  current minutes, 0..59.
- hours  output  5  current hours, 0..HOURS_MAX-1.
- secondTick  output  1  one-cycle pulse when seconds advances.
- minuteTick  output  1  one-cycle pulse when minutes advances.
- hourTick  output  1  one-cycle pulse when hours advances.
- tickLost  output  1  level: no secondClock rising edge seen for TIMEOUT_CYCLES.

Behaviour:
- Reset (resetN low, asynchronous):
  - synchronizer flops, edge-history flop, all time registers, all tick strobes, setError and tickLost clear to 0.
  - timeout counter clears to 0.
  - setReady is 0 while in reset and 1 from the first cycle after deassertion.
  - Reset mid-operation discards any pending edge or set.
- Synchronizer: secondClock passes through SYNC_STAGES flops, then one history flop.
  - Rising edge detected = (synchronized output high) and (history flop low).
  - Falling edges are ignored.
- Edge latency: a secondClock rise sampled at cmosClock edge N shows as an updated seconds value (with secondTick high) at edge N+SYNC_STAGES+1.
- Advance on detected edge:
  - seconds increments by 1 and secondTick pulses.
  - If seconds was 59: seconds wraps to 0, minutes increments, minuteTick pulses in the same cycle.
  - If minutes was also 59: minutes wraps to 0, hours increments, hourTick pulses.
  - Hours wraps from HOURS_MAX-1 to 0.
  - All carries settle in one cycle; there is no ripple latency.
- Set handshake: setReady is constantly 1 out of reset, and a load takes effect whenever setValid is high.
  - All fields in range: load seconds/minutes/hours on the next edge. No tick strobes pulse. Timeout counter clears.
  - Any field out of range: no load; setError pulses for one cycle.
  - Set and detected edge in the same cycle: set wins, the edge is dropped, no strobes.
  - Rejected set in the same cycle as an edge: the edge is processed normally.
  - setValid held high several cycles loads every cycle; the last value sticks.
- Timeout counter:
  - Increments every cycle and saturates at TIMEOUT_CYCLES.
  - Clears on a detected edge or an accepted set.
  - tickLost is high while counter == TIMEOUT_CYCLES and drops in the cycle after the clear.
  - Timekeeping continues unaffected by tickLost.
- Widths: the timeout counter is clog2(TIMEOUT_CYCLES+1) bits. All compares are unsigned.

Decomposition:
- Shared package clock_pkg holds:
  - SEC_W=6, MIN_W=6, HOUR_W=5;
  - SEC_MAX=59, MIN_MAX=59;
  - CMOS_HZ=100000000;
  - a time_t struct {hours, minutes, seconds}.
- One sub-module, edge_synchronizer: the SYNC_STAGES flop chain plus history flop, producing a one-cycle rising-edge pulse. It is reusable for button inputs.

Test Plan:
- Reset then hold secondClock low for 10 cycles → all outputs 0, setReady=1 after reset release, no strobes.
- Toggle secondClock with a rise every 20 cycles (TIMEOUT_CYCLES=50 in sim) → seconds 0,1,2… each update exactly SYNC_STAGES+1 cycles after the rise; secondTick one cycle each; falling edges cause nothing.
- Set 11:59:58 (HOURS_MAX=12), then 2 rises:
  - first rise → 11:59:59;
  - second rise → 00:00:00, with secondTick, minuteTick and hourTick all high in the same cycle.
- Set setMinutes=60 → setError pulses once, time unchanged. Then a valid set of 05:30:15 coincident with a detected edge → time reads 05:30:15, no strobes.
- Stop secondClock → tickLost rises exactly 50 cycles after the last edge-clear. The next rise clears tickLost and increments seconds.
- Assert resetN low mid-carry (at 23:59:59 with HOURS_MAX=24, while a rise is in the synchronizer) → outputs go to 0 immediately and the pending edge is lost after release.
